// File: rtl/div32s_restoring_seq.sv
// Sequential 32/16 signed restoring divider: one quotient bit per cycle over
// 32 cycles, quotient truncated toward zero, remainder signed like the dividend.
module div32s_restoring_seq (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   input  logic [31:0] i_dividend,
   input  logic [15:0] i_divisor,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [31:0] o_quotient,
   output logic [15:0] o_remainder,
   output logic        o_div_by_zero
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_dvd;       // dividend magnitude, becomes the quotient
   logic [16:0] r_dvs;       // 17 bits so |-32768| fits
   logic [16:0] r_rem;
   logic [4:0]  r_cnt;
   logic        r_sign_q, r_sign_r, r_zero;
   logic [15:0] r_raw_lo;
   logic [31:0] r_quo;
   logic [15:0] r_remo;
   logic        r_dbz;

   logic [31:0] w_dvd_abs;
   logic [16:0] w_dvs_ext, w_dvs_abs;
   logic [17:0] w_sh;
   logic [16:0] w_diff;
   logic        w_ge;

   assign w_dvd_abs = i_dividend[31] ? (32'd0 - i_dividend) : i_dividend;
   assign w_dvs_ext = {i_divisor[15], i_divisor};
   assign w_dvs_abs = i_divisor[15] ? (17'd0 - w_dvs_ext) : w_dvs_ext;

   // Trial subtract on the shifted partial remainder; the difference fits in
   // 17 bits whenever it is kept.
   assign w_sh   = {r_rem, r_dvd[31]};
   assign w_ge   = (w_sh >= {1'b0, r_dvs});
   assign w_diff = w_sh[16:0] - r_dvs;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_in_ready = 1'b1;
            if (i_in_valid) w_state_nxt = S_CALC;
         end
         S_CALC:  if (r_cnt == 5'd31) w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = S_DONE;
         S_DONE: begin
            o_out_valid = 1'b1;
            if (i_out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_dvd    <= '0;
         r_dvs    <= '0;
         r_rem    <= '0;
         r_cnt    <= '0;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_zero   <= 1'b0;
         r_raw_lo <= '0;
         r_quo    <= '0;
         r_remo   <= '0;
         r_dbz    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (i_in_valid) begin
               r_dvd    <= w_dvd_abs;
               r_dvs    <= w_dvs_abs;
               r_rem    <= '0;
               r_cnt    <= '0;
               r_sign_q <= i_dividend[31] ^ i_divisor[15];
               r_sign_r <= i_dividend[31];
               r_zero   <= (i_divisor == 16'd0);
               r_raw_lo <= i_dividend[15:0];
            end
            S_CALC: begin
               r_rem <= w_ge ? w_diff : w_sh[16:0];
               r_dvd <= {r_dvd[30:0], w_ge};
               r_cnt <= r_cnt + 5'd1;
            end
            S_FIX: begin
               if (r_zero) begin
                  r_quo  <= 32'hFFFF_FFFF;
                  r_remo <= r_raw_lo;
                  r_dbz  <= 1'b1;
               end else begin
                  r_quo  <= r_sign_q ? (32'd0 - r_dvd) : r_dvd;
                  r_remo <= r_sign_r ? (16'd0 - r_rem[15:0]) : r_rem[15:0];
                  r_dbz  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_quotient    = r_quo;
   assign o_remainder   = r_remo;
   assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_div32s_restoring_seq.sv
// Directed and reference-model checks for div32s_restoring_seq: results,
// fixed latency, handshake backpressure and mid-operation reset.
module tb_div32s_restoring_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   div32s_restoring_seq dut (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_dividend(dividend), .i_divisor(divisor), .o_out_valid(out_valid),
      .i_out_ready(out_ready), .o_quotient(quotient), .o_remainder(remainder),
      .o_div_by_zero(div_by_zero)
   );

   // All driving and sampling happens 1 time unit after the rising edge.
   task automatic start_op(input logic [31:0] a, input logic [15:0] b);
      in_valid = 1'b1; dividend = a; divisor = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 32'd0 ||
          remainder !== 16'd0 || div_by_zero !== 1'b0) begin
         fails++;
         $display("FAIL reset: rdy=%b vld=%b q=%h r=%h z=%b, want 1 0 0 0 0",
                  in_ready, out_valid, quotient, remainder, div_by_zero);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int lat;
      start_op(32'd100, 16'd7);
      tests++;
      if (in_ready !== 1'b0) begin
         fails++; $display("FAIL basic_busy: in_ready=%b want 0", in_ready);
      end
      wait_done(lat);
      tests++;
      if (lat != 33) begin
         fails++; $display("FAIL basic_latency: got %0d want 33", lat);
      end
      tests++;
      if (quotient !== 32'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0) begin
         fails++;
         $display("FAIL basic_result: q=%0d r=%0d z=%b want 14 2 0",
                  $signed(quotient), $signed(remainder), div_by_zero);
      end
      finish_op();
   endtask

   task automatic test_vectors();
      logic [31:0] va [8] = '{32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C, 32'h8000_0000,
                              32'h8000_0000, 32'h7FFF_FFFF, 32'h1234_5678, 32'd0};
      logic [15:0] vb [8] = '{16'd7, 16'hFFF9, 16'hFFF9, 16'hFFFF,
                              16'h8000, 16'h8000, 16'd0, 16'd5};
      logic [31:0] eq [8] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14, 32'h8000_0000,
                              32'd65536, 32'hFFFF_0001, 32'hFFFF_FFFF, 32'd0};
      logic [15:0] er [8] = '{16'hFFFE, 16'd2, 16'hFFFE, 16'd0,
                              16'd0, 16'h7FFF, 16'h5678, 16'd0};
      logic        ez [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      int lat;
      for (int i = 0; i < 8; i++) begin
         start_op(va[i], vb[i]);
         wait_done(lat);
         tests++;
         if (lat != 33 || quotient !== eq[i] || remainder !== er[i] ||
             div_by_zero !== ez[i]) begin
            fails++;
            $display("FAIL vec%0d %h/%h: lat=%0d q=%h r=%h z=%b want 33 %h %h %b",
                     i, va[i], vb[i], lat, quotient, remainder, div_by_zero,
                     eq[i], er[i], ez[i]);
         end
         finish_op();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      start_op(32'd1000, 16'd3);
      repeat (5) @(posedge clk);
      #1;
      in_valid = 1'b1; dividend = 32'd5; divisor = 16'd5;
      tests++;
      if (in_ready !== 1'b0) begin
         fails++; $display("FAIL bp_calc_ready: in_ready=%b want 0", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_done(lat);
      for (int c = 0; c < 10; c++) begin
         in_valid = (c == 0);
         tests++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 32'd333 ||
             remainder !== 16'd1 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold%0d: vld=%b rdy=%b q=%0d r=%0d want 1 0 333 1",
                     c, out_valid, in_ready, quotient, remainder);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      finish_op();
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL bp_release: rdy=%b vld=%b want 1 0", in_ready, out_valid);
      end
      start_op(32'd6, 16'd3);
      wait_done(lat);
      tests++;
      if (lat != 33 || quotient !== 32'd2 || remainder !== 16'd0) begin
         fails++;
         $display("FAIL bp_next: lat=%0d q=%0d r=%0d want 33 2 0", lat, quotient, remainder);
      end
      finish_op();
   endtask

   task automatic test_back_to_back();
      int lat;
      out_ready = 1'b1;
      start_op(32'd50, 16'd5);
      wait_done(lat);
      tests++;
      if (lat != 33 || out_valid !== 1'b1 || quotient !== 32'd10) begin
         fails++;
         $display("FAIL b2b_done: lat=%0d vld=%b q=%0d want 33 1 10", lat, out_valid, quotient);
      end
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL b2b_pulse: vld=%b rdy=%b want 0 1", out_valid, in_ready);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat;
      start_op(32'd1000, 16'd3);
      repeat (15) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 32'd0 ||
          remainder !== 16'd0 || div_by_zero !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid: rdy=%b vld=%b q=%h r=%h z=%b want 1 0 0 0 0",
                  in_ready, out_valid, quotient, remainder, div_by_zero);
      end
      start_op(32'd6, 16'd3);
      wait_done(lat);
      tests++;
      if (lat != 33 || quotient !== 32'd2 || remainder !== 16'd0) begin
         fails++;
         $display("FAIL rst_after: lat=%0d q=%0d r=%0d want 33 2 0", lat, quotient, remainder);
      end
      finish_op();
   endtask

   task automatic test_random();
      logic [31:0] a, eq;
      logic [15:0] b, er;
      logic        ez;
      longint      sa, sb, mq, mr;
      int          lat;
      for (int i = 0; i < 1000; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 16'd0;
            1:       b = 16'($urandom_range(1, 20));
            default: b = 16'($urandom);
         endcase
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         if (sb == 0) begin
            eq = 32'hFFFF_FFFF; er = a[15:0]; ez = 1'b1;
         end else begin
            mq = sa / sb;
            mr = sa % sb;
            eq = mq[31:0]; er = mr[15:0]; ez = 1'b0;
         end
         start_op(a, b);
         wait_done(lat);
         tests++;
         if (lat != 33 || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            fails++;
            $display("FAIL rand%0d %h/%h: lat=%0d q=%h r=%h z=%b want 33 %h %h %b",
                     i, a, b, lat, quotient, remainder, div_by_zero, eq, er, ez);
         end
         finish_op();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
